apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
- APB-style requester (initiator) that drives the 8-bit peripheral bus of the USRT bridge: pAddress, pWData, pWrite, pSelect and pEnable, qualified by pReady.
- Accepts single read or write commands over a valid/ready handshake and runs each as one SETUP/ACCESS transfer.
- Returns read data, or a timeout flag, on a one-cycle response strobe.
- Used as the bus master in system benches and in the host-side controller that programs and polls the USRT.

Parameters:
ADDR_W, 33, address width; matches the peripheral's pAddress.
DATA_W, 8, data width of pWData/pRData.
TIMEOUT, 16, maximum ACCESS cycles spent waiting for pReady; 0 disables the timeout.

Ports:
pClk  in  1  bus clock; single clock domain
pReset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_timeout  out  1  transfer aborted on timeout; valid with rsp_valid
pAddress  out  ADDR_W  bus address
pWData  out  DATA_W  bus write data
pWrite  out  1  bus direction
pSelect  out  1  bus select
pEnable  out  1  bus enable (access phase)
pRData  in  DATA_W  bus read data
pReady  in  1  completer ready / wait-state control

Behaviour:
- Reset (synchronous, sampled on the pClk rising edge):
  - state IDLE.
  - All bus outputs 0, rsp_valid 0, rsp_rdata 0, rsp_timeout 0.
  - cmd_ready 1 from the first cycle after reset.
- States are IDLE, SETUP and ACCESS; every output is registered.
- IDLE:
  - cmd_ready = 1; pSelect = 0, pEnable = 0.
  - On cmd_valid & cmd_ready: latch write, addr and wdata, then go to SETUP.
- SETUP (exactly one cycle):
  - pSelect = 1, pEnable = 0.
  - pAddress and pWrite driven from the latched command.
  - pWData = latched wdata on writes, 0 on reads.
  - cmd_ready = 0.
  - Next state is always ACCESS.
- ACCESS:
  - pSelect = 1, pEnable = 1.
  - pAddress, pWrite and pWData held stable for the whole phase.
  - pReady = 0: stay in ACCESS and increment the wait counter.
  - pReady = 1: sample pRData (reads only), return to IDLE, and pulse rsp_valid on the next cycle with rsp_timeout = 0.
  - Timeout (TIMEOUT != 0): when the wait counter equals TIMEOUT and pReady is still 0, abort.
    - Go to IDLE and drop pSelect/pEnable.
    - Next cycle: rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pReady = 1 and the timeout fire in the same cycle, pReady wins: normal completion.
- Wait counter:
  - Width ceil(log2(TIMEOUT+1)), minimum 1 bit.
  - Cleared on entry to ACCESS; saturates and never wraps.
- Latency: command accepted at edge N; SETUP in cycle N+1; ACCESS in N+2; with zero wait states rsp_valid is high in N+3.
- Each wait state adds one cycle.
- Back-to-back commands: cmd_ready is high in the same cycle as rsp_valid, so a new command can be accepted in that cycle. Minimum spacing is 3 cycles per transfer.
- rsp_rdata and rsp_timeout hold their last values after the strobe. They are meaningful only while rsp_valid = 1.
- cmd_valid while busy is ignored; the command is not accepted and not queued.
- Reset mid-transfer: next edge returns to IDLE with all outputs 0; no response is issued for the aborted command.
- pRData is ignored outside ACCESS. pReady is ignored outside ACCESS.

Decomposition:
- Shared package (usrt_bus_pkg):
  - state encoding IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
  - default ADDR_W/DATA_W constants, shared with the bridge's enable logic.
- One natural sub-module: apb_wait_timer.
  - Inputs: clear, count enable, TIMEOUT.
  - Output: expired.
  - Owns the saturating counter; the top level keeps the FSM and the registers.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd_write=1, addr=0x00000004, wdata=0xA5; pReady tied 1.
  - Response: one SETUP cycle (pSelect=1, pEnable=0), then one ACCESS cycle with pWData=0xA5; rsp_valid at N+3, rsp_timeout=0, rsp_rdata=0.
- Read, 3 wait states:
  - Stimulus: read of addr=0x00000008; pReady=0 for 3 ACCESS cycles; pRData=0x3C when pReady=1.
  - Response: rsp_valid at N+6 with rsp_rdata=0x3C; pAddress stable through ACCESS.
- Timeout:
  - Stimulus: TIMEOUT=4; read with pReady held 0.
  - Response: abort after 4 wait cycles; rsp_valid=1, rsp_timeout=1, rsp_rdata=0; pSelect returns to 0.
- Back-to-back:
  - Stimulus: cmd_valid held high with two writes (0x11, then 0x22); pReady=1.
  - Response: second command accepted in the rsp_valid cycle of the first; pSelect low for at least 1 cycle between transfers; responses 3 cycles apart.
- Reset mid-ACCESS:
  - Stimulus: pReset=1 during a wait state.
  - Response: next edge all outputs 0, no rsp_valid pulse, cmd_ready=1 after pReset falls.
- Busy ignore:
  - Stimulus: cmd_valid pulsed during SETUP with addr=0x1F.
  - Response: command not accepted; no extra transfer appears on the bus.

Source files
------------

// File: rtl/usrt_bus_pkg.sv
// Shared definitions for the USRT peripheral bus: requester state encoding
// and default bus widths used by the requester and the bridge enable logic.
package usrt_bus_pkg;

  localparam int unsigned USRT_ADDR_W = 33;
  localparam int unsigned USRT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Width of a counter that must reach 'timeout'; never narrower than 1 bit.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait-state counter. Flags expiry when the count
// reaches TIMEOUT; a TIMEOUT of 0 never expires.
module apb_wait_timer
  import usrt_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int unsigned     CNT_W     = wait_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // Count wait states; clear on entry to ACCESS and hold at the top value.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && (r_count == CNT_LIMIT);

endmodule

// File: rtl/apb_requester.sv
// APB-style requester for the USRT peripheral bus. Runs one SETUP/ACCESS
// transfer per accepted command and reports read data or a timeout on a
// one-cycle response strobe. All outputs are registered.
module apb_requester
  import usrt_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = USRT_ADDR_W,
  parameter int unsigned DATA_W  = USRT_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] pAddress,
  output logic [DATA_W-1:0] pWData,
  output logic              pWrite,
  output logic              pSelect,
  output logic              pEnable,
  input  logic [DATA_W-1:0] pRData,
  input  logic              pReady
);

  apb_state_t        r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_timeout;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic              r_psel;
  logic              r_penable;

  logic w_timer_clear;
  logic w_timer_count;
  logic w_expired;

  assign w_timer_clear = (r_state == SETUP);
  assign w_timer_count = (r_state == ACCESS) && !pReady;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_clk      (pClk),
    .i_reset    (pReset),
    .i_clear    (w_timer_clear),
    .i_count_en (w_timer_count),
    .o_expired  (w_expired)
  );

  // Transfer FSM; the bus address/data registers double as the command latch.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_state     <= SETUP;
            r_cmd_ready <= 1'b0;
            r_paddr     <= cmd_addr;
            r_pwrite    <= cmd_write;
            r_pwdata    <= cmd_write ? cmd_wdata : '0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          // pReady takes priority over a timeout firing in the same cycle.
          if (pReady || w_expired) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= !pReady;
            r_rsp_rdata   <= (pReady && !r_pwrite) ? pRData : '0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign pAddress    = r_paddr;
  assign pWData      = r_pwdata;
  assign pWrite      = r_pwrite;
  assign pSelect     = r_psel;
  assign pEnable     = r_penable;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester (TIMEOUT = 4). Stimulus pushes the
// expected response (data, timeout flag, strobe cycle); a negedge monitor
// pops and compares on every rsp_valid.
module tb_apb_requester;

  logic        pClk = 1'b0;
  logic        pReset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [32:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [32:0] pAddress;
  logic [7:0]  pWData;
  logic        pWrite;
  logic        pSelect;
  logic        pEnable;
  logic [7:0]  pRData;
  logic        pReady;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  rdata;
    logic        timeout;
    int unsigned at_cyc;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic        wr;
    logic [32:0] addr;
    logic [7:0]  wd;
    int unsigned waits;
    logic        rdy;
    logic [7:0]  rd;
    logic        poke;
    logic [7:0]  e_rd;
    logic        e_to;
    int unsigned e_lat;
  } vec_t;

  apb_requester #(
    .ADDR_W (33),
    .DATA_W (8),
    .TIMEOUT(4)
  ) dut (
    .pClk       (pClk),
    .pReset     (pReset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .pAddress   (pAddress),
    .pWData     (pWData),
    .pWrite     (pWrite),
    .pSelect    (pSelect),
    .pEnable    (pEnable),
    .pRData     (pRData),
    .pReady     (pReady)
  );

  always #5 pClk = ~pClk;

  always @(posedge pClk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge pClk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp cycle %0d got rsp_valid 1 expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
        chk("rsp_cycle",   64'(cyc),         64'(e.at_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic xfer(input vec_t v);
    int unsigned c0;
    logic [7:0]  ewd;
    ewd       = v.wr ? v.wd : 8'h00;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wd;
    pReady    = 1'b0;
    @(negedge pClk);
    chk("accept_ready", 64'(cmd_ready), 64'(1));
    c0 = cyc;
    exp_q.push_back('{v.e_rd, v.e_to, c0 + v.e_lat});
    tick();
    // SETUP cycle, optionally with a command that must be ignored.
    cmd_valid = v.poke;
    if (v.poke) begin
      cmd_write = 1'b1;
      cmd_addr  = 33'h1F;
      cmd_wdata = 8'hEE;
    end
    @(negedge pClk);
    chk("setup_psel",   64'(pSelect),   64'(1));
    chk("setup_pen",    64'(pEnable),   64'(0));
    chk("setup_addr",   64'(pAddress),  64'(v.addr));
    chk("setup_pwrite", 64'(pWrite),    64'(v.wr));
    chk("setup_wdata",  64'(pWData),    64'(ewd));
    chk("setup_ready",  64'(cmd_ready), 64'(0));
    tick();
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i <= v.waits; i++) begin
      pReady = (i == v.waits) ? v.rdy : 1'b0;
      pRData = (i == v.waits) ? v.rd : 8'hFF;
      @(negedge pClk);
      chk("access_psel",  64'(pSelect),  64'(1));
      chk("access_pen",   64'(pEnable),  64'(1));
      chk("access_addr",  64'(pAddress), 64'(v.addr));
      chk("access_wdata", 64'(pWData),   64'(ewd));
      tick();
    end
    pReady = 1'b0;
    pRData = 8'hAA;
    @(negedge pClk);
    chk("done_psel",  64'(pSelect),   64'(0));
    chk("done_pen",   64'(pEnable),   64'(0));
    chk("done_ready", 64'(cmd_ready), 64'(1));
    tick();
    @(negedge pClk);
    chk("idle_psel", 64'(pSelect), 64'(0));
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cycle %0d got no finish expected finish", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b1, 33'h000000004, 8'hA5, 0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 3};
    vecs[1] = '{1'b0, 33'h000000008, 8'h00, 3, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0, 6};
    vecs[2] = '{1'b0, 33'h1000000C0, 8'h00, 4, 1'b0, 8'h99, 1'b0, 8'h00, 1'b1, 7};
    vecs[3] = '{1'b0, 33'h000000020, 8'h00, 4, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0, 7};
    vecs[4] = '{1'b1, 33'h0000001F0, 8'h0F, 2, 1'b1, 8'h66, 1'b1, 8'h00, 1'b0, 5};
    vecs[5] = '{1'b0, 33'h000000002, 8'h00, 0, 1'b1, 8'hC3, 1'b1, 8'hC3, 1'b0, 3};
    vecs[6] = '{1'b1, 33'h000000030, 8'h81, 4, 1'b0, 8'h12, 1'b0, 8'h00, 1'b1, 7};

    pReset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pRData    = 8'h00;
    pReady    = 1'b0;
    tick();
    tick();
    @(negedge pClk);
    chk("rst_psel",    64'(pSelect),     64'(0));
    chk("rst_pen",     64'(pEnable),     64'(0));
    chk("rst_addr",    64'(pAddress),    64'(0));
    chk("rst_wdata",   64'(pWData),      64'(0));
    chk("rst_pwrite",  64'(pWrite),      64'(0));
    chk("rst_rspv",    64'(rsp_valid),   64'(0));
    chk("rst_rdata",   64'(rsp_rdata),   64'(0));
    chk("rst_timeout", 64'(rsp_timeout), 64'(0));
    chk("rst_ready",   64'(cmd_ready),   64'(1));
    tick();
    pReset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) xfer(vecs[k]);

    // Reset during an ACCESS wait state: no response may follow.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 33'h55;
    pReady    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pReset = 1'b1;
    tick();
    @(negedge pClk);
    chk("mrst_psel",  64'(pSelect),   64'(0));
    chk("mrst_pen",   64'(pEnable),   64'(0));
    chk("mrst_addr",  64'(pAddress),  64'(0));
    chk("mrst_rspv",  64'(rsp_valid), 64'(0));
    chk("mrst_ready", 64'(cmd_ready), 64'(1));
    pReset = 1'b0;
    tick();
    @(negedge pClk);
    chk("post_rst_ready", 64'(cmd_ready), 64'(1));
    chk("post_rst_psel",  64'(pSelect),   64'(0));
    tick();

    // Back-to-back writes with cmd_valid held high.
    begin
      int unsigned c0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 33'h10;
      cmd_wdata = 8'h11;
      pReady    = 1'b1;
      @(negedge pClk);
      c0 = cyc;
      exp_q.push_back('{8'h00, 1'b0, c0 + 3});
      tick();
      cmd_addr  = 33'h14;
      cmd_wdata = 8'h22;
      @(negedge pClk);
      chk("b2b_setup1_wdata", 64'(pWData), 64'(8'h11));
      tick();
      @(negedge pClk);
      chk("b2b_access1_addr", 64'(pAddress), 64'(33'h10));
      tick();
      @(negedge pClk);
      chk("b2b_gap_psel",  64'(pSelect),   64'(0));
      chk("b2b_gap_ready", 64'(cmd_ready), 64'(1));
      exp_q.push_back('{8'h00, 1'b0, c0 + 6});
      tick();
      cmd_valid = 1'b0;
      @(negedge pClk);
      chk("b2b_setup2_psel",  64'(pSelect),  64'(1));
      chk("b2b_setup2_wdata", 64'(pWData),   64'(8'h22));
      chk("b2b_setup2_addr",  64'(pAddress), 64'(33'h14));
      tick();
      tick();
      pReady = 1'b0;
      tick();
    end

    repeat (4) tick();
    @(negedge pClk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
